hermes_local_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one Hermes router local input port among `N_SOURCES` injecting requesters (e.g. processor NI and DMA engine). It sits between the requesters and the router's local-port `rx_i`/`credit_o`/`data_i` lines. It locks a grant for the duration of a full Hermes packet (header flit, size flit, `size` payload flits), then passes ownership to the next requester in round-robin order.

---
 rtl/hermes_local_arbiter.sv | 152 +++++++++++++++
 tb/tb_hermes_local_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hermes_local_arbiter.sv
// rtl/hermes_local_arbiter.sv - packet-level round-robin arbiter for a Hermes router local input port
//
// Shares one Hermes local input port among N_SOURCES requesters. Ownership is
// locked for a whole packet (header flit, size flit, size payload flits) and
// then passed round-robin starting after the previous owner.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   src_tx_i      per-requester flit valid
//   src_data_i    per-requester flit, requester i at [i*FLIT_SIZE +: FLIT_SIZE]
//   src_credit_o  per-requester flit accepted this cycle
//   tx_o          flit valid toward the router
//   data_o        flit toward the router
//   credit_i      router local buffer has space
//   grant_o       one-hot current owner, zero when idle
//   busy_o        packet in progress
module hermes_local_arbiter #(
    parameter int N_SOURCES = 2,
    parameter int FLIT_SIZE = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [N_SOURCES-1:0]           src_tx_i,
    input  logic [N_SOURCES*FLIT_SIZE-1:0] src_data_i,
    output logic [N_SOURCES-1:0]           src_credit_o,
    output logic                           tx_o,
    output logic [FLIT_SIZE-1:0]           data_o,
    input  logic                           credit_i,
    output logic [N_SOURCES-1:0]           grant_o,
    output logic                           busy_o
);

    localparam int IDX_W = $clog2(N_SOURCES);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        SIZE,
        PAYLOAD
    } state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] g, g_nx;
    logic [IDX_W-1:0] rr, rr_nx;
    logic [15:0]      cnt, cnt_nx;
    logic             xfer;
    logic             pkt_end;
    logic             found;
    logic [IDX_W-1:0] sel;
    int               j;

    assign busy_o = (state != IDLE);
    assign xfer   = tx_o && credit_i;

    // Grant mux: purely combinational from the registered owner, so the
    // router's credit reaches the owning requester in the same cycle.
    always_comb begin
        grant_o      = '0;
        src_credit_o = '0;
        tx_o         = 1'b0;
        data_o       = '0;
        if (state != IDLE) begin
            grant_o[g]      = 1'b1;
            src_credit_o[g] = credit_i;
            tx_o            = src_tx_i[g];
            data_o          = src_data_i[int'(g)*FLIT_SIZE +: FLIT_SIZE];
        end
    end

    always_comb begin
        state_nx = state;
        g_nx     = g;
        rr_nx    = rr;
        cnt_nx   = cnt;
        pkt_end  = 1'b0;
        found    = 1'b0;
        sel      = rr;
        j        = 0;

        case (state)
            IDLE: begin
                // First requester at or after rr, wrapping past the top index.
                for (int i = 0; i < N_SOURCES; i++) begin
                    j = int'(rr) + i;
                    if (j >= N_SOURCES) begin
                        j = j - N_SOURCES;
                    end
                    if (!found && src_tx_i[j]) begin
                        found = 1'b1;
                        sel   = IDX_W'(j);
                    end
                end
                if (found) begin
                    g_nx     = sel;
                    state_nx = HEADER;
                end
            end
            HEADER: begin
                if (xfer) begin
                    state_nx = SIZE;
                end
            end
            SIZE: begin
                if (xfer) begin
                    // Only the low 16 bits carry the payload length.
                    cnt_nx = data_o[15:0];
                    if (data_o[15:0] == 16'd0) begin
                        pkt_end = 1'b1;
                    end else begin
                        state_nx = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    cnt_nx = cnt - 16'd1;
                    if (cnt == 16'd1) begin
                        pkt_end = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (pkt_end) begin
            state_nx = IDLE;
            if (int'(g) == N_SOURCES - 1) begin
                rr_nx = '0;
            end else begin
                rr_nx = g + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            g     <= '0;
            rr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            g     <= g_nx;
            rr    <= rr_nx;
            cnt   <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_hermes_local_arbiter.sv
// tb/tb_hermes_local_arbiter.sv - directed self-checking bench for hermes_local_arbiter
module tb_hermes_local_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  src_tx;
    logic [63:0] src_data;
    logic [1:0]  src_credit;
    logic        tx;
    logic [31:0] data;
    logic        credit;
    logic [1:0]  grant;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [1:0]  lg_g[$];
    logic [31:0] lg_d[$];
    int          lg_c[$];
    logic [31:0] e[$];
    logic [1:0]  eg[$];

    hermes_local_arbiter #(.N_SOURCES(2), .FLIT_SIZE(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .src_tx_i    (src_tx),
        .src_data_i  (src_data),
        .src_credit_o(src_credit),
        .tx_o        (tx),
        .data_o      (data),
        .credit_i    (credit),
        .grant_o     (grant),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        src_tx[0] = (q0.size() != 0);
        src_tx[1] = (q1.size() != 0);
        src_data[31:0]  = (q0.size() != 0) ? q0[0] : 32'h0;
        src_data[63:32] = (q1.size() != 0) ? q1[0] : 32'h0;
    endtask

    task automatic clear_log();
        lg_g.delete();
        lg_d.delete();
        lg_c.delete();
    endtask

    task automatic wait_log(input int n);
        int b;
        b = 0;
        while (lg_d.size() < n && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (lg_d.size() < n) chk("timeout_log", 64'(lg_d.size()), 64'(n));
    endtask

    // Requester models: pop a flit after each edge at which it was accepted.
    initial begin
        logic a0, a1;
        forever begin
            @(posedge clk);
            a0 = src_credit[0] && src_tx[0];
            a1 = src_credit[1] && src_tx[1];
            #1;
            if (a0 && q0.size() != 0) void'(q0.pop_front());
            if (a1 && q1.size() != 0) void'(q1.pop_front());
            refresh();
        end
    end

    // Transfer log sampled on the edge where the flit moves.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst_n && tx && credit) begin
                lg_g.push_back(grant);
                lg_d.push_back(data);
                lg_c.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        src_tx   = 2'b00;
        src_data = 64'h0;
        credit   = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tx", 64'(tx), 64'(0));
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_credit", 64'(src_credit), 64'(0));
        chk("rst_data", 64'(data), 64'(0));
        rst_n  = 1'b1;
        credit = 1'b1;
        @(negedge clk);
        chk("rst_rr", 64'(dut.rr), 64'(0));
        chk("rst_cnt", 64'(dut.cnt), 64'(0));

        // Single source, size 3
        clear_log();
        e = '{32'h0000_0101, 32'h0000_0003, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003};
        foreach (e[k]) q0.push_back(e[k]);
        refresh();
        chk("s1_grant_req_cycle", 64'(grant), 64'(0));
        @(negedge clk);
        chk("s1_grant", 64'(grant), 64'(2'b01));
        chk("s1_tx", 64'(tx), 64'(1));
        chk("s1_hdr", 64'(data), 64'(32'h101));
        wait_log(5);
        chk("s1_count", 64'(lg_d.size()), 64'(5));
        for (int k = 0; k < 5; k++) chk("s1_data", 64'(lg_d[k]), 64'(e[k]));
        chk("s1_span", 64'(lg_c[4] - lg_c[0]), 64'(4));
        chk("s1_busy", 64'(busy), 64'(0));
        chk("s1_rr", 64'(dut.rr), 64'(1));

        // Contention, size-2 packets; rr = 1 so source 1 goes first
        clear_log();
        q0 = '{32'h100, 32'h2, 32'hA0, 32'hA1, 32'h100, 32'h2, 32'hA2, 32'hA3};
        q1 = '{32'h200, 32'h2, 32'hB0, 32'hB1, 32'h200, 32'h2, 32'hB2, 32'hB3};
        refresh();
        wait_log(16);
        e  = '{32'h200, 32'h2, 32'hB0, 32'hB1, 32'h100, 32'h2, 32'hA0, 32'hA1,
               32'h200, 32'h2, 32'hB2, 32'hB3, 32'h100, 32'h2, 32'hA2, 32'hA3};
        eg = '{2'b10, 2'b01, 2'b10, 2'b01};
        for (int k = 0; k < 16; k++) begin
            chk("s2_data", 64'(lg_d[k]), 64'(e[k]));
            chk("s2_grant", 64'(lg_g[k]), 64'(eg[k/4]));
        end
        for (int k = 0; k < 4; k++) chk("s2_pkt_span", 64'(lg_c[4*k+3] - lg_c[4*k]), 64'(3));
        for (int k = 1; k < 4; k++) chk("s2_gap", 64'(lg_c[4*k] - lg_c[4*k-1]), 64'(2));
        chk("s2_rr", 64'(dut.rr), 64'(1));

        // Backpressure on a size-4 packet; size flit upper bits are ignored
        clear_log();
        e = '{32'h300, 32'hFFFF_0004, 32'hC0, 32'hC1, 32'hC2, 32'hC3};
        foreach (e[k]) q0.push_back(e[k]);
        refresh();
        wait_log(4);
        credit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("s3_tx_held", 64'(tx), 64'(1));
            chk("s3_cnt_held", 64'(dut.cnt), 64'(2));
            chk("s3_no_credit", 64'(src_credit), 64'(0));
            chk("s3_no_xfer", 64'(lg_d.size()), 64'(4));
        end
        credit = 1'b1;
        wait_log(6);
        @(negedge clk);
        chk("s3_count", 64'(lg_d.size()), 64'(6));
        for (int k = 0; k < 6; k++) chk("s3_data", 64'(lg_d[k]), 64'(e[k]));
        chk("s3_busy", 64'(busy), 64'(0));

        // Zero-size packet from source 1, pointer wraps
        clear_log();
        q1 = '{32'h400, 32'h0};
        refresh();
        wait_log(2);
        chk("s4_grant_h", 64'(lg_g[0]), 64'(2'b10));
        chk("s4_grant_s", 64'(lg_g[1]), 64'(2'b10));
        chk("s4_grant_end", 64'(grant), 64'(0));
        chk("s4_busy", 64'(busy), 64'(0));
        chk("s4_rr", 64'(dut.rr), 64'(0));

        // Lock-in: source 1 requests during source 0 payload
        clear_log();
        q0 = '{32'h500, 32'h3, 32'hD0, 32'hD1, 32'hD2};
        refresh();
        wait_log(3);
        q1 = '{32'h600, 32'h0};
        refresh();
        chk("s5_lock_credit", 64'(src_credit[1]), 64'(0));
        chk("s5_lock_grant", 64'(grant), 64'(2'b01));
        wait_log(5);
        chk("s5_idle_grant", 64'(grant), 64'(0));
        @(negedge clk);
        chk("s5_next_grant", 64'(grant), 64'(2'b10));
        wait_log(7);
        for (int k = 0; k < 5; k++) chk("s5_src0", 64'(lg_g[k]), 64'(2'b01));
        chk("s5_src1_h", 64'(lg_g[5]), 64'(2'b10));
        chk("s5_src1_s", 64'(lg_g[6]), 64'(2'b10));
        chk("s5_gap", 64'(lg_c[5] - lg_c[4]), 64'(2));

        // Move pointer to 1 before the reset test
        q0 = '{32'h700, 32'h0};
        refresh();
        wait_log(9);
        chk("s6_pre_rr", 64'(dut.rr), 64'(1));

        // Reset mid-packet
        clear_log();
        q1 = '{32'h800, 32'h5, 32'hE0, 32'hE1, 32'hE2, 32'hE3, 32'hE4};
        refresh();
        wait_log(3);
        chk("s6_busy_pre", 64'(busy), 64'(1));
        chk("s6_grant_pre", 64'(grant), 64'(2'b10));
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_tx", 64'(tx), 64'(0));
        chk("s6_grant", 64'(grant), 64'(0));
        chk("s6_busy", 64'(busy), 64'(0));
        chk("s6_credit", 64'(src_credit), 64'(0));
        q0.delete();
        q1.delete();
        refresh();
        @(negedge clk);
        rst_n = 1'b1;
        chk("s6_rr", 64'(dut.rr), 64'(0));
        chk("s6_cnt", 64'(dut.cnt), 64'(0));
        clear_log();
        q0 = '{32'h900, 32'h0};
        q1 = '{32'hA00, 32'h0};
        refresh();
        @(negedge clk);
        chk("s6_rearb", 64'(grant), 64'(2'b01));
        wait_log(4);
        chk("s6_first_src", 64'(lg_g[0]), 64'(2'b01));
        chk("s6_second_src", 64'(lg_g[2]), 64'(2'b10));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
